// File: rtl/seq_mul_pkg.sv
// Shared state encodings and legal WIDTH range for the sequential multiplier.
package seq_mul_pkg;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/seq_array_multiplier_if.sv
// Operand/product handshake bundle for seq_array_multiplier.
// signed_mode exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_array_multiplier_if #(
   parameter int unsigned WIDTH = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;
`ifdef SEQ_MUL_SIGNED_EN
   logic               signed_mode;
`endif

   modport master (
`ifdef SEQ_MUL_SIGNED_EN
      output signed_mode,
`endif
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
`ifdef SEQ_MUL_SIGNED_EN
      input  signed_mode,
`endif
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mul_add_stage.sv
// WIDTH-bit ripple-carry adder built from full_adder cells.
module mul_add_stage #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);
   logic [WIDTH:0] c;

   assign c[0]  = 1'b0;
   assign carry = c[WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end
endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: one partial-product row per clock, WIDTH cycles per product.
// Define SEQ_MUL_SIGNED_EN to add two's-complement operation selected by signed_mode.
module seq_array_multiplier
   import seq_mul_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input logic                   clk,
   input logic                   rst_n,
   seq_array_multiplier_if.slave bus
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("seq_array_multiplier: WIDTH out of range");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   // Upper half accumulates; lower half starts as the multiplier and fills with product bits.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0]   add_b, add_sum;
   logic               add_carry;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] result;
   logic [WIDTH-1:0]   mag_a, mag_b;

   assign add_b    = acc_q[0] ? mcand_q : '0;
   assign acc_step = {add_carry, add_sum, acc_q[WIDTH-1:1]};

   mul_add_stage #(
      .WIDTH (WIDTH)
   ) u_add (
      .a     (acc_q[2*WIDTH-1:WIDTH]),
      .b     (add_b),
      .sum   (add_sum),
      .carry (add_carry)
   );

`ifdef SEQ_MUL_SIGNED_EN
   localparam logic [WIDTH-1:0]   OneW = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] OneP = (2*WIDTH)'(1);

   logic sign_q, sign_d;
   logic neg_a, neg_b;

   assign neg_a  = bus.signed_mode & bus.a[WIDTH-1];
   assign neg_b  = bus.signed_mode & bus.b[WIDTH-1];
   assign mag_a  = neg_a ? (~bus.a + OneW) : bus.a;
   assign mag_b  = neg_b ? (~bus.b + OneW) : bus.b;
   assign result = sign_q ? (~acc_step + OneP) : acc_step;
`else
   assign mag_a  = bus.a;
   assign mag_b  = bus.b;
   assign result = acc_step;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
`ifdef SEQ_MUL_SIGNED_EN
      sign_d    = sign_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               mcand_d = mag_a;
               acc_d   = {{WIDTH{1'b0}}, mag_b};
               cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
               sign_d  = neg_a ^ neg_b;
`endif
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               product_d = result;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
         sign_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
         sign_q    <= sign_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.product   = product_q;

endmodule
